// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port data RAM between the CPU data port and a debug /
//   loader master. One access is issued per cycle. Under contention the
//   current holder keeps the RAM for up to MAX_BURST consecutive cycles, then
//   the other requester is served (round robin). Read data comes back one
//   cycle after the grant, qualified by a per-requester rvalid strobe.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   cpu_req/wr/addr/wr_data       CPU request, held until cpu_gnt
//   cpu_gnt, cpu_stall            access issued this cycle / waiting
//   cpu_rvalid, cpu_rd_data       read return (data bus shared with dbg)
//   dbg_*                         same set for the debug master (no stall)
//   mem_wr_sig/addr/wr_data       RAM command
//   mem_rd_data                   RAM read data, one cycle after address
module ram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rd_data,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              mem_wr_sig,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic            OWN_CPU = 1'b0;
  localparam logic            OWN_DBG = 1'b1;

  typedef enum logic [1:0] {IDLE, HOLD_CPU, HOLD_DBG} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]       rd_pend_q, rd_pend_d;   // [0] CPU, [1] DBG
  logic             gnt_cpu, gnt_dbg;
  logic [CNT_W-1:0] burst_inc;

  assign burst_inc = (burst_cnt_q == MAX_CNT) ? MAX_CNT : burst_cnt_q + CNT_W'(1);

  always_comb begin
    gnt_cpu     = 1'b0;
    gnt_dbg     = 1'b0;
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;

    if (cpu_req && dbg_req) begin
      // Holder keeps the RAM until its burst budget is spent, then the
      // requester that is not the last owner wins.
      if (state_q == HOLD_CPU && burst_cnt_q < MAX_CNT)      gnt_cpu = 1'b1;
      else if (state_q == HOLD_DBG && burst_cnt_q < MAX_CNT) gnt_dbg = 1'b1;
      else if (owner_q == OWN_DBG)                           gnt_cpu = 1'b1;
      else                                                   gnt_dbg = 1'b1;
    end else begin
      gnt_cpu = cpu_req;
      gnt_dbg = dbg_req;
    end

    if (!reset_n) begin
      gnt_cpu = 1'b0;
      gnt_dbg = 1'b0;
    end

    if (gnt_cpu) begin
      owner_d     = OWN_CPU;
      state_d     = HOLD_CPU;
      burst_cnt_d = (state_q == HOLD_CPU) ? burst_inc : CNT_W'(1);
    end else if (gnt_dbg) begin
      owner_d     = OWN_DBG;
      state_d     = HOLD_DBG;
      burst_cnt_d = (state_q == HOLD_DBG) ? burst_inc : CNT_W'(1);
    end else begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end

    rd_pend_d = {gnt_dbg & ~dbg_wr, gnt_cpu & ~cpu_wr};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_DBG;   // CPU wins the first tie after reset
      burst_cnt_q <= '0;
      rd_pend_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign cpu_gnt   = gnt_cpu;
  assign dbg_gnt   = gnt_dbg;
  assign cpu_stall = reset_n & cpu_req & ~gnt_cpu;

  // With no grant the address/data follow the CPU so an idle debug master
  // leaves the RAM pins looking like a direct CPU connection.
  assign mem_addr    = gnt_dbg ? dbg_addr    : cpu_addr;
  assign mem_wr_data = gnt_dbg ? dbg_wr_data : cpu_wr_data;
  assign mem_wr_sig  = (gnt_cpu & cpu_wr) | (gnt_dbg & dbg_wr);

  // Gating with reset_n drops a read return that lands in a reset cycle.
  assign cpu_rvalid  = rd_pend_q[0] & reset_n;
  assign dbg_rvalid  = rd_pend_q[1] & reset_n;
  assign cpu_rd_data = mem_rd_data;
  assign dbg_rd_data = mem_rd_data;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wr_data = '0;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rd_data;
  logic          dbg_req = 1'b0, dbg_wr = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wr_data = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rd_data;
  logic          mem_wr_sig;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rd_data(cpu_rd_data),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rd_data(dbg_rd_data),
    .mem_wr_sig(mem_wr_sig), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // RAM environment: registered read, one cycle latency.
  logic          ram_init = 1'b1;
  logic [DW-1:0] ram [0:63];
  logic [DW-1:0] mem_rd_q;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hC0DE_0000 + i;
    end else if (mem_wr_sig) begin
      ram[mem_addr[7:2]] <= mem_wr_data;
    end
    mem_rd_q <= ram[mem_addr[7:2]];
  end
  assign mem_rd_data = mem_rd_q;

  // Expected RAM contents, maintained from the stimulus alone.
  logic [DW-1:0] shadow [0:63];

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t cpu_q[$];
  exp_t dbg_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Read-return monitor: each rvalid must match the scoreboard head exactly
  // in the cycle it is due, and never appear otherwise.
  bit mon_en = 1'b0;
  bit cv, dv;
  always @(negedge clk) if (mon_en) begin
    cv = (cpu_q.size() > 0) && (cpu_q[0].cyc == cyc);
    dv = (dbg_q.size() > 0) && (dbg_q[0].cyc == cyc);
    chk("cpu_rvalid", 64'(cpu_rvalid), 64'(cv));
    chk("dbg_rvalid", 64'(dbg_rvalid), 64'(dv));
    if (cv) begin chk("cpu_rd_data", 64'(cpu_rd_data), 64'(cpu_q[0].data)); void'(cpu_q.pop_front()); end
    if (dv) begin chk("dbg_rd_data", 64'(dbg_rd_data), 64'(dbg_q[0].data)); void'(dbg_q.pop_front()); end
  end

  typedef struct {
    logic          rst_n;
    logic          creq, cwr;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdat;
    logic          dreq, dwr;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddat;
    logic          ecg, edg;   // expected grants
  } vec_t;

  function automatic vec_t mk(input logic rst_n,
                              input logic creq, input logic cwr, input logic [AW-1:0] caddr, input logic [DW-1:0] cdat,
                              input logic dreq, input logic dwr, input logic [AW-1:0] daddr, input logic [DW-1:0] ddat,
                              input logic ecg, input logic edg);
    vec_t v;
    v.rst_n = rst_n; v.creq = creq; v.cwr = cwr; v.caddr = caddr; v.cdat = cdat;
    v.dreq = dreq; v.dwr = dwr; v.daddr = daddr; v.ddat = ddat; v.ecg = ecg; v.edg = edg;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Apply one cycle of stimulus, check the combinational grant outputs,
  // update the shadow RAM and queue expected read returns.
  task automatic step(input vec_t v);
    exp_t e;
    reset_n = v.rst_n;
    cpu_req = v.creq; cpu_wr = v.cwr; cpu_addr = v.caddr; cpu_wr_data = v.cdat;
    dbg_req = v.dreq; dbg_wr = v.dwr; dbg_addr = v.daddr; dbg_wr_data = v.ddat;
    if (!v.rst_n) begin
      cpu_q.delete();
      dbg_q.delete();
    end
    @(negedge clk);
    chk("cpu_gnt", 64'(cpu_gnt), 64'(v.ecg));
    chk("dbg_gnt", 64'(dbg_gnt), 64'(v.edg));
    chk("cpu_stall", 64'(cpu_stall), 64'(v.rst_n & v.creq & ~v.ecg));
    chk("mem_wr_sig", 64'(mem_wr_sig), 64'((v.ecg & v.cwr) | (v.edg & v.dwr)));
    chk("mem_addr", 64'(mem_addr), 64'(v.edg ? v.daddr : v.caddr));
    chk("mem_wr_data", 64'(mem_wr_data), 64'(v.edg ? v.ddat : v.cdat));
    if (v.ecg) begin
      if (v.cwr) shadow[v.caddr[7:2]] = v.cdat;
      else begin e.data = shadow[v.caddr[7:2]]; e.cyc = cyc + 1; cpu_q.push_back(e); end
    end
    if (v.edg) begin
      if (v.dwr) shadow[v.daddr[7:2]] = v.ddat;
      else begin e.data = shadow[v.daddr[7:2]]; e.cyc = cyc + 1; dbg_q.push_back(e); end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 32'hC0DE_0000 + i;

    // Reset with both requesting, then 12 cycles of contention.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 32'h20, 0, 1, 0, 32'h24, 0, 0, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(1, 1, 0, 32'h20, 0, 1, 0, 32'h24, 0, (i < 4 || i >= 8), (i >= 4 && i < 8)));
    tbl.push_back(idle());
    // CPU alone: write then read back.
    tbl.push_back(mk(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle());
    // Loader fills 0x0..0x1C, then CPU reads the last word.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'(4 * i), 32'(i + 1), 0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h1C, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle());
    // Read interleave.
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'hA, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h4, 32'hB, 0, 1));
    tbl.push_back(idle());
    tbl.push_back(mk(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1));
    tbl.push_back(idle());
    tbl.push_back(idle());

    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 3) ram_init = 1'b0;
      step(tbl[i]);
    end

    // Reset mid-read: DBG read granted, reset next cycle, pending rvalid
    // must vanish; state returns to IDLE so CPU wins the tie after release.
    step(mk(1, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1));
    step(mk(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0, 0));
    step(mk(1, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 1, 0));
    step(idle());

    // Cancelled request: CPU stalls behind a DBG burst, then drops its
    // write; the RAM word must keep the loader value.
    step(mk(1, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1));
    step(mk(1, 1, 1, 32'h8, 32'h55, 1, 0, 32'h4, 0, 0, 1));
    step(mk(1, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1));
    step(idle());
    step(mk(1, 1, 0, 32'h8, 0, 0, 0, 0, 0, 1, 0));
    step(idle());

    // Burst count saturates during a long solo DBG run; the first tie
    // afterwards goes straight to the CPU.
    for (int i = 0; i < 6; i++) step(mk(1, 0, 0, 0, 0, 1, 0, 32'(4 * i), 0, 0, 1));
    step(mk(1, 1, 0, 32'h18, 0, 1, 0, 32'h1C, 0, 1, 0));
    step(mk(1, 1, 0, 32'h18, 0, 1, 0, 32'h1C, 0, 1, 0));
    step(mk(1, 0, 0, 0, 0, 1, 0, 32'h1C, 0, 0, 1));
    step(idle());
    step(idle());

    chk("scoreboard_drained", 64'(cpu_q.size() + dbg_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port data RAM between the CPU data port and a debug/loader master (program loader, memory inspector). Sits between `cpu` / debug master and `ram`. Grants one access per cycle with round-robin priority and a bounded burst, and returns read data with a per-requester valid strobe. When the debug master is idle it is transparent to the CPU except for one cycle of read latency tagging.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, max consecutive grants to one requester while the other is requesting (≥1)

- `clk`  in  1  clock; all state updates on rising edge
- `reset_n`  in  1  reset; synchronous, active-low
- `cpu_req`  in  1  CPU access request, held until granted
- `cpu_wr`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wr_data`  in  DATA_W  CPU write data
- `cpu_gnt`  out  1  CPU access issued to RAM this cycle
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rd_data`  out  DATA_W  CPU read data
- `dbg_req`, `dbg_wr`, `dbg_addr`, `dbg_wr_data`, `dbg_gnt`, `dbg_rvalid`, `dbg_rd_data`: same as the CPU set, debug master side
- `mem_wr_sig`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wr_data`  out  DATA_W  RAM write data
- `mem_rd_data`  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- State: `owner` (0 = CPU, 1 = DBG), `burst_cnt` (0..MAX_BURST, saturating), `rd_pend` (2 bits: pending read for CPU/DBG).
- FSM states: IDLE (no grant last cycle), HOLD_CPU, HOLD_DBG (that requester was granted last cycle).
- Grant decision, combinational, per cycle:
  - no req: no grant; next state IDLE, `burst_cnt` ← 0, `owner` unchanged.
  - one req: grant it.
  - both req: if in HOLD_x and `burst_cnt < MAX_BURST`, grant x; otherwise grant the requester ≠ `owner`.
- On grant to x: if x == previous holder (HOLD_x), `burst_cnt` ← min(`burst_cnt`+1, MAX_BURST); else `burst_cnt` ← 1. `owner` ← x; next state HOLD_x.
- Mem mux: `mem_addr`/`mem_wr_data` follow the granted requester; with no grant they follow the CPU inputs. `mem_wr_sig` = grant & that requester's `wr`.
- Read return: a granted read sets `rd_pend[x]` for the next cycle; `x_rvalid` = `rd_pend[x]`; `x_rd_data` = `mem_rd_data` (both buses carry it; only rvalid qualifies).
- Writes produce no rvalid.

## Timing
- Reset values (while `reset_n` low and after the edge): `owner` = DBG (CPU wins the first tie), `burst_cnt` = 0, state IDLE, `rd_pend` = 0.
- While `reset_n` is low, all grants, `mem_wr_sig`, `cpu_stall`, and both rvalids are forced to 0 combinationally.
- Grant latency: 0 cycles; the req seen in cycle N is granted in cycle N when it wins.
- Read latency: rvalid exactly 1 cycle after the granted cycle.
- Back-to-back grants allowed every cycle; throughput is 1 access/cycle.
- Requester must keep req, wr, addr, and wr_data stable until the cycle gnt=1. Dropping req before grant cancels with no side effect.
- Reset asserted the cycle after a granted read: the pending rvalid is suppressed and never appears.
- MAX_BURST=1: strict alternation under continuous contention.
- Worst-case wait under contention: MAX_BURST cycles.

## Test plan
- Reset: hold `reset_n`=0 with both req=1 for 3 cycles -> both gnt=0, `mem_wr_sig`=0, both rvalid=0; release -> first cycle `cpu_gnt`=1.
- CPU only: write 0xDEADBEEF @0x10, then read @0x10 -> `mem_wr_sig`=1 in cycle 1, `cpu_gnt` both cycles, `cpu_rvalid`=1 with `cpu_rd_data`=0xDEADBEEF in cycle 3, `cpu_stall`=0 throughout.
- Contention, MAX_BURST=4, both req continuously for 12 cycles -> grant pattern CPU×4, DBG×4, CPU×4; `cpu_stall`=1 exactly in cycles 5–8.
- Debug loader writes 0x1..0x8 to 0x0..0x1C while CPU idle, then CPU reads 0x1C -> CPU gets 0x8 with no stall.
- Read interleave: CPU reads @0x0 (=0xA) in cycle N and DBG reads @0x4 (=0xB) in cycle N+1 -> `cpu_rvalid` only at N+1 with 0xA; `dbg_rvalid` only at N+2 with 0xB.
- Reset mid-read: granted DBG read in cycle N, `reset_n`=0 in cycle N+1 -> `dbg_rvalid` stays 0; after release with both req, CPU wins.
